// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, 8 x 16-bit words per line, zero-cycle hit, in-order line fill
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int NUM_BLOCKS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic [15:0] cpu_instr,
  output logic        stall,
  input  logic        flush,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_valid,
  input  logic [15:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [NUM_BLOCKS-1:0]  valid;
  logic [TAG_W-1:0]       tags [NUM_BLOCKS];
  logic [15:0]            data [NUM_BLOCKS*8];
  logic [15:0]            base;
  logic [2:0]             issue_cnt;
  logic [2:0]             recv_cnt;
  logic                   issue_done;
  logic                   flush_pend;

  logic [2:0]             req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic [IDX_W+2:0]       rd_ptr;
  logic [IDX_W+2:0]       wr_ptr;
  logic                   hit;
  logic                   unused_bits;

  assign req_off     = cpu_addr[3:1];
  assign req_idx     = cpu_addr[4 +: IDX_W];
  assign req_tag     = cpu_addr[15 -: TAG_W];
  assign fill_idx    = base[4 +: IDX_W];
  assign fill_tag    = base[15 -: TAG_W];
  assign rd_ptr      = {req_idx, req_off};
  assign wr_ptr      = {fill_idx, recv_cnt};
  assign unused_bits = cpu_addr[0] ^ (|base[3:0]);

  assign hit = (state == IDLE) && valid[req_idx] && (tags[req_idx] == req_tag);

  // Everything visible to the pipeline and memory is forced quiet during reset.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    cpu_instr = 16'd0;
    mem_en    = 1'b0;
    mem_addr  = 16'd0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          stall = cpu_req & ~hit;
          if (cpu_req && hit) begin
            cpu_instr = data[rd_ptr];
          end
          if (cpu_req && !hit) begin
            state_nxt = FILL;
          end
        end
        FILL: begin
          stall  = 1'b1;
          mem_en = ~issue_done;
          if (!issue_done) begin
            mem_addr = base + 16'({issue_cnt, 1'b0});
          end
          if (mem_valid && recv_cnt == 3'd7) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          stall     = 1'b1;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      base       <= 16'd0;
      issue_cnt  <= 3'd0;
      recv_cnt   <= 3'd0;
      issue_done <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end
          if (cpu_req && !hit) begin
            base       <= cpu_addr & 16'hFFF0;
            issue_cnt  <= 3'd0;
            recv_cnt   <= 3'd0;
            issue_done <= 1'b0;
            flush_pend <= 1'b0;
          end
        end
        FILL: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (!issue_done) begin
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == 3'd7) begin
              issue_done <= 1'b1;
            end
          end
          if (mem_valid) begin
            recv_cnt <= recv_cnt + 3'd1;
          end
        end
        DONE: begin
          // A flush seen at any point of the fill discards the new line along with the rest.
          if (flush_pend || flush) begin
            valid <= '0;
          end else begin
            valid[fill_idx] <= 1'b1;
          end
          flush_pend <= 1'b0;
        end
        default: begin
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == FILL && mem_valid) begin
      data[wr_ptr] <= mem_data;
    end
    if (rst_n && state == DONE) begin
      tags[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else begin
      if (cpu_req && hit && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      if (state == IDLE && cpu_req && !hit && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized scoreboard bench for icache against a line-level reference model
// Stats counters are checked only when ICACHE_STATS_EN is defined.
module tb_icache;

  localparam int NB = 32;
  localparam int IW = $clog2(NB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = 16'd0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = 16'd0;
  logic [15:0] cpu_instr;
  logic        stall;
  logic        mem_en;
  logic [15:0] mem_addr;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  icache #(.NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .stall     (stall),
    .flush     (flush),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        hit;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [32768];
  exp_t        sb_q[$];
  logic [15:0] fill_q[$];
  logic [15:0] pend_q[$];
  bit          mv [NB];
  logic [15:0] mt [NB];
  int          stall_cyc = 0;
  int          bk = 0;
  bit          after8 = 1'b0;
  logic [15:0] bbase;
  logic [15:0] rsp_addr;
  exp_t        e;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one tag + valid per line, indexed by address / 16.
  function automatic bit model_hit(input logic [15:0] a);
    int idx;
    idx = int'(a[15:4]) % NB;
    return mv[idx] && (mt[idx] == (a >> (4 + IW)));
  endfunction

  function automatic void model_set(input logic [15:0] a);
    int idx;
    idx = int'(a[15:4]) % NB;
    mv[idx] = 1'b1;
    mt[idx] = a >> (4 + IW);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) mv[i] = 1'b0;
  endfunction

  // Response monitor: each served request pops one expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall", 16'(stall), 16'd0);
      chk("rst_mem_en", 16'(mem_en), 16'd0);
      chk("rst_mem_addr", mem_addr, 16'd0);
      chk("rst_instr", cpu_instr, 16'd0);
      stall_cyc = 0;
    end else begin
      if (!cpu_req || stall) chk("instr_zero", cpu_instr, 16'd0);
      if (cpu_req) begin
        if (stall) begin
          stall_cyc++;
        end else begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got response %h expected none", cpu_instr);
          end else begin
            e = sb_q.pop_front();
            chk("instr", cpu_instr, e.data);
            if (e.hit) begin
              chk("hit_latency", 16'(stall_cyc), 16'd0);
            end else begin
              checks++;
              if (stall_cyc < 10) begin
                errors++;
                $display("FAIL miss_latency: got %0d stall cycles expected >= 10", stall_cyc);
              end
            end
          end
          stall_cyc = 0;
        end
      end
    end
  end

  // Fill-burst checker: 8 consecutive issues at the expected line base.
  always @(negedge clk) begin
    if (!rst_n) begin
      bk = 0;
      after8 = 1'b0;
    end else begin
      if (after8) begin
        chk("mem_en_len", 16'(mem_en), 16'd0);
        after8 = 1'b0;
      end
      if (mem_en) begin
        if (bk == 0) begin
          if (fill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fill: got mem_addr %h expected no fill", mem_addr);
            bbase = mem_addr & 16'hFFF0;
          end else begin
            bbase = fill_q.pop_front();
          end
        end
        chk("mem_addr", mem_addr, bbase + 16'(2 * bk));
        pend_q.push_back(mem_addr);
        bk++;
        if (bk == 8) begin
          bk = 0;
          after8 = 1'b1;
        end
      end else if (bk != 0) begin
        checks++;
        errors++;
        $display("FAIL mem_en_gap: got %0d issues expected 8", bk);
        bk = 0;
      end
    end
  end

  // Memory: in-order returns with random delay.
  always @(posedge clk) begin
    #1;
    mem_valid = 1'b0;
    if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      rsp_addr  = pend_q.pop_front();
      mem_valid = 1'b1;
      mem_data  = mem[rsp_addr[15:1]];
    end
  end

  task automatic abort_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    fill_q.delete();
    model_clear();
    for (int n = 0; n < 200 && pend_q.size() > 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 flush on 4th returned word, 2 reset after 3rd word, 3 flush with request in IDLE
  task automatic do_req(input logic [15:0] a, input int mode);
    bit hit;
    bit done;
    int rcv;
    rcv = 0;
    done = 1'b0;
    hit = model_hit(a);
    sb_q.push_back('{data: mem[a[15:1]], hit: hit});
    if (!hit) fill_q.push_back(a & 16'hFFF0);
    if (mode == 1) fill_q.push_back(a & 16'hFFF0);
    if (mode == 1 || mode == 3) model_clear();
    if (!hit || mode == 1) model_set(a);
    cpu_addr = a;
    cpu_req = 1'b1;
    if (mode == 3) flush = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (mem_valid) rcv++;
      if (!stall) begin
        done = 1'b1;
      end else if (mode == 1 && mem_valid && rcv == 4) begin
        flush = 1'b1;
      end else if (mode == 2 && rcv == 3) begin
        abort_reset();
        return;
      end
      @(posedge clk); #1;
      flush = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no response for %h expected one within 400 cycles", a);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_req(16'h0024, 0);
    for (int a = 16'h20; a <= 16'h2E; a += 2) do_req(16'(a), 0);
`ifdef ICACHE_STATS_EN
    chk("miss_cnt", miss_cnt, 16'd1);
    chk("hit_cnt", hit_cnt, 16'd9);
`endif

    do_req(16'h0020, 0);
    do_req(16'h0220, 0);
    do_req(16'h0020, 0);
    do_req(16'hFFF6, 0);
    do_req(16'hFFFE, 0);
    do_req(16'h0021, 3);
    do_req(16'h0020, 0);
    do_req(16'h0120, 1);
    do_req(16'h0120, 0);
    do_req(16'h0340, 2);
    do_req(16'h0340, 0);
    do_req(16'h034A, 0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cpu_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_req(16'(($urandom_range(0, 3) * 512) + ($urandom_range(0, 7) * 16) + $urandom_range(0, 15)),
             ($urandom_range(0, 19) == 0) ? 3 : 0);
    end

    cpu_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 32, meaning the number of direct-mapped lines (power of two, 16..64), each 8 x 16-bit words.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset: synchronous and active-low.
REQ-004 SHALL have port cpu_req, input, 1 bit, a fetch request for cpu_addr this cycle.
REQ-005 SHALL have port cpu_addr, input, 16 bits, the fetch byte address (from the PC).
REQ-006 SHALL have port cpu_instr, output, 16 bits, the instruction word; valid when cpu_req=1 and stall=0.
REQ-007 SHALL have port stall, output, 1 bit, high while the request cannot be served; it drives the PC/IF-ID write-enable hold.
REQ-008 SHALL have port flush, input, 1 bit, invalidate all lines.
REQ-009 SHALL have port mem_en, output, 1 bit, main-memory read request.
REQ-010 SHALL have port mem_addr, output, 16 bits, main-memory word byte address.
REQ-011 SHALL have port mem_valid, input, 1 bit, main-memory data return strobe.
REQ-012 SHALL have port mem_data, input, 16 bits, the returned word; responses return in issue order.

Function
REQ-013 SHALL decode cpu_addr as: bit0 ignored; [3:1] word offset; next log2(NUM_BLOCKS) bits index; remaining upper bits tag.
REQ-014 SHALL declare a hit when the indexed line is valid, its tag matches, and the state is IDLE; on a hit, cpu_instr SHALL be the addressed word combinationally in the same cycle, with stall=0 (zero-cycle hit).
REQ-015 SHALL drive stall = cpu_req & ~hit in IDLE, and stall=1 in FILL and DONE.
REQ-016 SHALL use the FSM states IDLE, FILL and DONE; IDLE->FILL on cpu_req & ~hit; FILL->DONE when the 8th mem_valid is received; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL, on entering FILL, latch the line-aligned miss address (cpu_addr & 16'hFFF0); later changes on cpu_addr SHALL be ignored until IDLE.
REQ-018 SHALL, in FILL, assert mem_en for exactly 8 consecutive cycles with mem_addr = base, base+2, ..., base+14 (3-bit issue counter).
REQ-019 SHALL, on each mem_valid in FILL, write mem_data into word recv_cnt of the line and then increment recv_cnt (3-bit, 0..7); mem_valid outside FILL SHALL be ignored.
REQ-020 SHALL, in DONE, write the tag and set the valid bit, unless a flush is pending.
REQ-021 SHALL, on flush in IDLE, clear all valid bits at the clock edge; stall that cycle SHALL still reflect the pre-flush contents.
REQ-022 SHALL, on flush in FILL, record it as pending and let the fill complete; in DONE, clear all valid bits and leave the new line invalid; the pending flag SHALL then clear.
REQ-023 SHALL hold cpu_instr at 0 whenever stall=1 or cpu_req=0.
REQ-024 SHALL wrap address increments modulo 2^16 (the line at 0xFFF0 fetches 0xFFF0..0xFFFE).

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear all valid bits, set the state to IDLE, and clear the issue/receive counters and the flush-pending flag.
REQ-026 SHALL force stall=0, mem_en=0, mem_addr=0 and cpu_instr=0 combinationally while rst_n=0.
REQ-027 SHALL abort a fill in progress on reset; the partial line stays invalid and mem_valid responses arriving after reset are ignored.

Configuration
REQ-028 SHALL, with ICACHE_STATS_EN defined, add outputs hit_cnt[15:0] and miss_cnt[15:0], incremented once per hit cycle and once per IDLE->FILL transition, saturating at 16'hFFFF and cleared by reset.
REQ-029 SHALL, without ICACHE_STATS_EN, have no such ports or counters; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover cold miss: after reset, cpu_req=1, cpu_addr=16'h0024 -> stall=1, mem_en=1 for 8 cycles at 0x0020..0x002E, DONE, then a hit returning the word from 0x0024.
REQ-031 SHALL cover hit after fill: cpu_addr 0x0020..0x002E sequential -> stall=0 every cycle, cpu_instr matches memory.
REQ-032 SHALL cover conflict: addresses 0x0020 then 0x0220 (same index, 32 blocks) -> second access misses and refills; 0x0020 then misses again.
REQ-033 SHALL cover flush: flush pulsed during the 4th returned word of a fill -> the fill completes, the line is invalid, and the next access to the same address misses.
REQ-034 SHALL cover reset mid-fill: rst_n=0 after 3 returned words -> stall=0, mem_en=0, and the next request to the same line misses and refetches all 8 words.
REQ-035 SHALL cover stats (ICACHE_STATS_EN): REQ-030 then REQ-031 -> miss_cnt=1, hit_cnt=9.
